// File: rtl/xs3_bcd_decoder.sv
// xs3_bcd_decoder: serial Excess-3 digits (MSD first) -> packed BCD word with error flag.
// Latency: out_valid rises on the edge accepting the DIGITS-th digit; one word per DIGITS+1 cycles peak.
// Backpressure: in HOLD in_ready=0 and the word is held stable until out_valid && out_ready.
//
// Optional feature macro: XS3_ERR_CNT_EN adds err_cnt, an 8-bit saturating invalid-digit counter.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clr                synchronous abort of the word in progress (err_cnt unaffected)
//   in_valid/in_ready  digit handshake, in_xs3 = Excess-3 digit
//   out_valid/out_ready word handshake, out_bcd = packed BCD (first digit in top nibble)
//   out_err            at least one digit of the word was an invalid code
//   err_cnt            (XS3_ERR_CNT_EN only) count of accepted invalid digits, saturates at 255
module xs3_bcd_decoder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_xs3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_err
`ifdef XS3_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [4*DIGITS-1:0] shift_q;
  logic [CW-1:0]       cnt_q;
  logic                err_q;

  logic                dig_ok;
  logic [3:0]          dig_bcd;
  logic                in_fire;
  logic                out_fire;
  logic                last_dig;

  // Valid codes are 3..12; anything else decodes to F and flags the word.
  assign dig_ok   = (in_xs3 >= 4'd3) && (in_xs3 <= 4'd12);
  assign dig_bcd  = dig_ok ? (in_xs3 - 4'd3) : 4'hF;

  // clr discards any handshake occurring in the same cycle.
  assign in_fire  = in_valid && in_ready && !clr;
  assign out_fire = out_valid && out_ready && !clr;
  assign last_dig = (cnt_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_fire && last_dig) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_fire) begin
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
    if (clr) begin
      state_nxt = COLLECT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (clr || out_fire) begin
      shift_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (in_fire) begin
      shift_q <= {shift_q[4*DIGITS-5:0], dig_bcd};
      err_q   <= err_q | ~dig_ok;
      cnt_q   <= last_dig ? '0 : cnt_q + 1'b1;
    end
  end

  assign out_bcd = shift_q;
  assign out_err = err_q;

`ifdef XS3_ERR_CNT_EN
  // Counts per accepted digit, not per word; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (in_fire && !dig_ok && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xs3_bcd_decoder.sv
module tb_xs3_bcd_decoder;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_xs3;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bcd;
  logic        out_err;
`ifdef XS3_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  xs3_bcd_decoder #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_xs3    (in_xs3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_err   (out_err)
`ifdef XS3_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a digit and wait (bounded) for the edge that accepts it; in_valid stays high.
  task automatic send_digit(input logic [3:0] x);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_xs3   = x;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    if (!done) check("send_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_xs3    = 4'd0;
    out_ready = 1'b1;
    #2;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bcd",   32'(out_bcd),   32'h0);
    check("rst_out_err",   32'(out_err),   32'd0);
`ifdef XS3_ERR_CNT_EN
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
`endif
    #6 rst_n = 1'b1;
    tick();

    // Basic word: 4,5,6,7 -> 1234, back-to-back.
    send_digit(4'b0100);
    send_digit(4'b0101);
    send_digit(4'b0110);
    send_digit(4'b0111);
    in_valid = 1'b0;
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_bcd",   32'(out_bcd),   32'h1234);
    check("basic_err",   32'(out_err),   32'd0);
    check("basic_rdy",   32'(in_ready),  32'd0);
    tick();
    check("basic_valid_1cyc", 32'(out_valid), 32'd0);
    check("basic_rdy_back",   32'(in_ready),  32'd1);
    check("basic_bcd_clr",    32'(out_bcd),   32'h0);

    // Code boundaries: 3, C valid; 2, D invalid.
    send_digit(4'b0011);
    send_digit(4'b1100);
    send_digit(4'b0010);
    send_digit(4'b1101);
    in_valid = 1'b0;
    check("bound_valid", 32'(out_valid), 32'd1);
    check("bound_bcd",   32'(out_bcd),   32'h09FF);
    check("bound_err",   32'(out_err),   32'd1);
`ifdef XS3_ERR_CNT_EN
    check("bound_err_cnt", 32'(err_cnt), 32'd2);
`endif
    tick();
    check("bound_done", 32'(out_valid), 32'd0);

    // Backpressure with gaps: 9876 -> C,B,A,9.
    out_ready = 1'b0;
    send_digit(4'hC);
    in_valid = 1'b0;
    repeat ($urandom_range(1, 3)) tick();
    send_digit(4'hB);
    in_valid = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
    send_digit(4'hA);
    in_valid = 1'b0;
    repeat ($urandom_range(1, 3)) tick();
    check("gap_not_yet", 32'(out_valid), 32'd0);
    send_digit(4'h9);
    in_xs3 = 4'h4;  // offered during HOLD, must be ignored
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_bcd",   32'(out_bcd),   32'h9876);
      check("bp_rdy",   32'(in_ready),  32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_rdy_after", 32'(in_ready),  32'd1);
    check("bp_valid_off", 32'(out_valid), 32'd0);
    check("bp_bcd_clear", 32'(out_bcd),   32'h0);

    // clr abort mid-word (with a discarded digit in the clr cycle), then 0042.
    send_digit(4'h4);
    send_digit(4'h5);
    clr    = 1'b1;
    in_xs3 = 4'h6;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_bcd",   32'(out_bcd),  32'h0);
    check("clr_rdy",   32'(in_ready), 32'd1);
    send_digit(4'h3);
    send_digit(4'h3);
    send_digit(4'h7);
    send_digit(4'h5);
    in_valid = 1'b0;
    check("clr_word_valid", 32'(out_valid), 32'd1);
    check("clr_word_bcd",   32'(out_bcd),   32'h0042);
    check("clr_word_err",   32'(out_err),   32'd0);
    // clr also abandons a held word.
    out_ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_hold_valid", 32'(out_valid), 32'd0);
    check("clr_hold_rdy",   32'(in_ready),  32'd1);
    out_ready = 1'b1;

    // Async reset mid-word after 3 digits.
    send_digit(4'h4);
    send_digit(4'h5);
    send_digit(4'h6);
    in_valid = 1'b0;
    check("pre_rst_bcd", 32'(out_bcd), 32'h123);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bcd",   32'(out_bcd),   32'h0);
    check("arst_rdy",   32'(in_ready),  32'd1);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_err",   32'(out_err),   32'd0);
`ifdef XS3_ERR_CNT_EN
    check("arst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    #1 rst_n = 1'b1;
    tick();
    send_digit(4'h8);
    send_digit(4'h9);
    send_digit(4'hA);
    send_digit(4'hB);
    in_valid = 1'b0;
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_bcd",   32'(out_bcd),   32'h5678);
    tick();

`ifdef XS3_ERR_CNT_EN
    // Saturation: 300 invalid digits.
    for (int i = 0; i < 300; i++) begin
      send_digit(4'hF);
      if (i == 199) check("sat_mid", 32'(err_cnt), 32'd200);
    end
    in_valid = 1'b0;
    check("sat_255", 32'(err_cnt), 32'd255);
    tick();
    tick();
    check("sat_hold", 32'(err_cnt), 32'd255);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("sat_clr", 32'(err_cnt), 32'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xs3_bcd_decoder.md
# xs3_bcd_decoder

Serial Excess-3 to packed-BCD decoder: the receive-side counterpart of the team's BCD-to-Excess-3 encoder. Accepts one Excess-3 digit per handshake, most-significant digit first, validates and subtracts 3, and assembles `DIGITS` digits into a packed BCD word. The word is presented on a valid/ready output port with a per-word error flag.

## Interface
- `DIGITS`, default 4: digits per output word, from 2 to 8.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clr` input 1: synchronous abort of the word in progress; it does not clear the error counter.
- `in_valid` input 1: `in_xs3` holds a digit.
- `in_ready` output 1: decoder can accept a digit.
- `in_xs3` input 4: Excess-3 digit. Valid codes are 4'b0011 through 4'b1100.
- `out_valid` output 1: `out_bcd` and `out_err` hold a complete word.
- `out_ready` input 1: downstream accepts the word.
- `out_bcd` output 4*DIGITS: packed BCD. The first received digit is in the top nibble.
- `out_err` output 1: at least one digit of the word was an invalid code.
- `err_cnt` output 8: exists only with `XS3_ERR_CNT_EN`.

## Operation
- The FSM has two states, COLLECT and HOLD. Reset state is COLLECT.
- **COLLECT**
  - `in_ready` = 1 and `out_valid` = 0.
  - A digit transfers on a cycle where `in_valid` and `in_ready` are both high.
  - On each transfer, the shift register moves left by one nibble and the decoded nibble enters the low nibble.
  - The digit counter increments (width `$clog2(DIGITS+1)`) and the error flag accumulates (OR).
  - On the `DIGITS`-th transfer, the FSM goes to HOLD and the counter returns to 0.
- **Decode rule**
  - Valid code x: nibble = x − 3, computed in 4 bits.
  - Invalid code (x < 3 or x > 12): nibble = 4'hF and the word error flag is set.
- **HOLD**
  - `in_ready` = 0 and `out_valid` = 1.
  - `out_bcd` and `out_err` stay stable until `out_valid` and `out_ready` are both high.
  - On that transfer, the FSM goes to COLLECT. The shift register, counter and error flag clear to 0.
- **`clr`**
  - In either state, `clr` = 1 forces COLLECT on the next edge and clears the shift register, counter and error flag.
  - Any digit or word handshake in that same cycle is discarded.
  - `clr` has priority over every other input.
- **`in_valid` gaps**: allowed at any point. The counter holds and no timeout exists.
- **`in_valid` during HOLD**: ignored, because `in_ready` = 0. The upstream must hold its digit until `in_ready` returns.
- **Reset values**: `in_ready` = 1, `out_valid` = 0, `out_bcd` = 0, `out_err` = 0, `err_cnt` = 0, FSM = COLLECT.

## Timing
- All outputs are registered or decoded directly from FSM state; there is no combinational input-to-output path.
- `out_valid` rises on the edge that accepts the `DIGITS`-th digit, so it is visible one cycle after that digit's handshake cycle.
- Earliest next digit accept is the cycle after the output handshake. Peak throughput is one word per `DIGITS`+1 cycles.
- Reset asserted mid-word or mid-HOLD immediately returns every output to its reset value. Partial data is lost.

## Configuration
- **`XS3_ERR_CNT_EN` defined**
  - Adds the `err_cnt` port, an 8-bit saturating counter.
  - It increments by 1 for each accepted invalid digit, not per word, and holds at 255.
  - It is unaffected by `clr` and word handshakes; only `rst_n` clears it.
- **`XS3_ERR_CNT_EN` undefined**: the port and counter are absent. All other behaviour is identical.

## Test plan
- **Basic word**: with `DIGITS`=4, send 4'b0100, 4'b0101, 4'b0110, 4'b0111 back-to-back with `out_ready` = 1 → `out_bcd` = 16'h1234, `out_err` = 0, `out_valid` high for 1 cycle.
- **Code boundaries**: send 4'b0011, 4'b1100, 4'b0010, 4'b1101 → `out_bcd` = 16'h09FF, `out_err` = 1. With the macro defined, `err_cnt` = 2.
- **Backpressure and gaps**:
  - Send 16'h9876-encoding digits with random `in_valid` gaps, and hold `out_ready` = 0 for 5 cycles after `out_valid`.
  - Required: `out_bcd` stable at 16'h9876 and `in_ready` = 0 throughout; `in_ready` = 1 the cycle after the handshake.
- **`clr` abort**: send 2 digits, pulse `clr`, then send the digits for 16'h0042 → `out_bcd` = 16'h0042 and `out_err` = 0.
- **Async reset mid-word**: assert `rst_n` low between edges after 3 digits → outputs go to reset values immediately. Next 4 digits yield a correct word.
- **Counter saturation** (macro defined): 300 invalid digits (4'b1111) → `err_cnt` = 255 and stays there. A subsequent `clr` leaves it at 255.
